uart_cmd_arb: RTL and testbench

//   Shares the single UART command port (cmd_in/cmd_vld/cmd_rdy, read_rdy/read_data) between N_REQ requesters.
//   - Round-robin arbitration; one outstanding command at a time.
//   - Holds the command until the UART accepts it and tracks completion.
//   - Returns read data or an error to the owning requester.
//   - Sits between on-chip masters and the uart command engine.
//

---
 rtl/uart_cmd_arb_pkg.sv | 24 ++
 rtl/uart_cmd_arb_rr_arbiter.sv | 54 +++++
 rtl/uart_cmd_arb.sv | 171 +++++++++++++++++
 tb/tb_uart_cmd_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_arb_pkg.sv
// Shared types and defaults for the UART command arbiter.
// FSM encodings, default widths and the read/write flag position within a command.
package uart_cmd_arb_pkg;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_CMD_WIDTH  = 16;
    localparam int DEF_READ_WIDTH = 8;
    localparam int DEF_TIMEOUT    = 60000;
    localparam int DEF_TO_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_BUSY     = 3'd2,
        ST_RESP_OK  = 3'd3,
        ST_RESP_ERR = 3'd4
    } state_e;

    // The MSB of a command selects write (1) or read (0).
    function automatic int cmd_rw_bit(input int cmd_width);
        return cmd_width - 1;
    endfunction

endpackage

// File: rtl/uart_cmd_arb_rr_arbiter.sv
// Round-robin picker: first request at or after the pointer wins, wrapping to 0.
// Grant is combinational; the pointer moves to winner+1 only when the grant is taken.
module uart_cmd_arb_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    localparam int CW = IDX_W + 1;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cand;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + CW'(i);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                 = 1'b1;
                gnt[cand[IDX_W-1:0]]  = 1'b1;
                gnt_idx               = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/uart_cmd_arb.sv
// Shares one UART command port among N_REQ requesters, one command in flight at a time.
// cmd_vld rises 1 cycle after grant; response pulses 1 cycle after completion; req_rdy stays low while busy.
module uart_cmd_arb
    import uart_cmd_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
    parameter int READ_WIDTH = DEF_READ_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int TO_W       = DEF_TO_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ*CMD_WIDTH-1:0] req_cmd,
    input  logic [N_REQ-1:0]           req_vld,
    output logic [N_REQ-1:0]           req_rdy,
    output logic [READ_WIDTH-1:0]      rsp_data,
    output logic [N_REQ-1:0]           rsp_vld,
    output logic [N_REQ-1:0]           rsp_err,
    output logic [CMD_WIDTH-1:0]       cmd_in,
    output logic                       cmd_vld,
    input  logic                       cmd_rdy,
    input  logic                       read_rdy,
    input  logic [READ_WIDTH-1:0]      read_data
);

    localparam int            IDX_W   = $clog2(N_REQ);
    localparam int            RW_BIT  = cmd_rw_bit(CMD_WIDTH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic                  cmd_vld_q, cmd_vld_d;
    logic [TO_W-1:0]       cnt_q, cnt_d;
    logic [N_REQ-1:0]      rsp_vld_q, rsp_vld_d;
    logic [N_REQ-1:0]      rsp_err_q, rsp_err_d;
    logic [READ_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [N_REQ-1:0]      arb_req;
    logic [N_REQ-1:0]      gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  accept;
    logic [CMD_WIDTH-1:0]  sel_cmd;
    logic [N_REQ-1:0]      owner_oh;
    logic                  cmd_wr;

    // Offer requests to the arbiter only when both this block and the engine are idle.
    assign arb_req = (state_q == ST_IDLE && cmd_rdy) ? req_vld : '0;
    assign req_rdy = gnt;
    assign accept  = |(req_vld & gnt);
    assign cmd_wr  = cmd_q[RW_BIT];

    uart_cmd_arb_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .accept  (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_cmd = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
            end
        end
    end

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        cmd_vld_d  = cmd_vld_q;
        cnt_d      = cnt_q;
        rsp_vld_d  = '0;
        rsp_err_d  = '0;
        rsp_data_d = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_d     = sel_cmd;
                    owner_d   = gnt_idx;
                    cmd_vld_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!cmd_rdy) begin
                    cmd_vld_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_BUSY;
                end else if (cnt_q == TO_LAST) begin
                    cmd_vld_d = 1'b0;
                    rsp_err_d = owner_oh;
                    state_d   = ST_RESP_ERR;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + TO_W'(1);
                // Read data beats both the engine going idle and the timeout in the same cycle.
                if (!cmd_wr && read_rdy) begin
                    rsp_data_d = read_data;
                    rsp_vld_d  = owner_oh;
                    state_d    = ST_RESP_OK;
                end else if (cmd_rdy) begin
                    if (cmd_wr) begin
                        rsp_vld_d = owner_oh;
                        state_d   = ST_RESP_OK;
                    end else begin
                        rsp_err_d = owner_oh;
                        state_d   = ST_RESP_ERR;
                    end
                end else if (cnt_q == TO_LAST) begin
                    rsp_err_d = owner_oh;
                    state_d   = ST_RESP_ERR;
                end
            end
            ST_RESP_OK,
            ST_RESP_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                cmd_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            cmd_q      <= '0;
            cmd_vld_q  <= 1'b0;
            cnt_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_err_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cmd_q      <= cmd_d;
            cmd_vld_q  <= cmd_vld_d;
            cnt_q      <= cnt_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign cmd_in   = cmd_q;
    assign cmd_vld  = cmd_vld_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_err  = rsp_err_q;
    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_uart_cmd_arb.sv
// Directed bench for uart_cmd_arb; a second instance with a short timeout covers expiry timing.
module tb_uart_cmd_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] rc [4];
    logic [63:0] req_cmd;
    logic [3:0]  req_vld, req_rdy, rsp_vld, rsp_err;
    logic [7:0]  rsp_data, read_data;
    logic [15:0] cmd_in;
    logic        cmd_vld, cmd_rdy, read_rdy;

    logic [3:0]  b_req_vld, b_req_rdy, b_rsp_vld, b_rsp_err;
    logic [7:0]  b_rsp_data;
    logic [15:0] b_cmd_in;
    logic        b_cmd_vld;

    assign req_cmd = {rc[3], rc[2], rc[1], rc[0]};

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;
    int k_err;
    logic [3:0] err_seen;
    logic [3:0] exp_g;

    uart_cmd_arb #(
        .N_REQ(4), .CMD_WIDTH(16), .READ_WIDTH(8), .TIMEOUT(1000), .TO_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_vld(req_vld), .req_rdy(req_rdy),
        .rsp_data(rsp_data), .rsp_vld(rsp_vld), .rsp_err(rsp_err),
        .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .read_rdy(read_rdy), .read_data(read_data)
    );

    uart_cmd_arb #(
        .N_REQ(4), .CMD_WIDTH(16), .READ_WIDTH(8), .TIMEOUT(100), .TO_W(16)
    ) u_dut_to (
        .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_vld(b_req_vld), .req_rdy(b_req_rdy),
        .rsp_data(b_rsp_data), .rsp_vld(b_rsp_vld), .rsp_err(b_rsp_err),
        .cmd_in(b_cmd_in), .cmd_vld(b_cmd_vld), .cmd_rdy(cmd_rdy),
        .read_rdy(read_rdy), .read_data(read_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_vld = '0; b_req_vld = '0;
        cmd_rdy = 1'b1; read_rdy = 1'b0; read_data = '0;
        foreach (rc[i]) rc[i] = '0;

        // Reset values
        cyc(2);
        chk("rst_cmd_vld", cmd_vld, 0);
        chk("rst_cmd_in", cmd_in, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_data", rsp_data, 0);
        rst = 1'b0;

        // Round-robin with all requesters held: 0,1,2,3,0,1,2,3
        rc[0] = 16'h8101; rc[1] = 16'h8202; rc[2] = 16'h8303; rc[3] = 16'h8404;
        req_vld = 4'hF;
        for (int k = 0; k < 8; k++) begin
            exp_g = 4'b0001 << (k % 4);
            #1 chk("rr_grant", req_rdy, exp_g);
            cyc();
            chk("rr_cmd_vld", cmd_vld, 1);
            chk("rr_cmd_in", cmd_in, rc[k % 4]);
            chk("rr_stall", req_rdy, 0);
            cmd_rdy = 1'b0;
            cyc();
            chk("rr_accepted", cmd_vld, 0);
            cmd_rdy = 1'b1;
            if (k == 7) req_vld = '0;
            cyc();
            chk("rr_rsp_vld", rsp_vld, exp_g);
            chk("rr_rsp_err", rsp_err, 0);
            cyc();
        end

        // Single write from requester 0, engine busy for 200 cycles
        rc[0] = 16'h8A55; req_vld = 4'b0001;
        #1 chk("wr_grant", req_rdy, 4'b0001);
        cyc();
        req_vld = '0;
        chk("wr_cmd_vld", cmd_vld, 1);
        chk("wr_cmd_in", cmd_in, 16'h8A55);
        cyc(2);
        cmd_rdy = 1'b0;
        cyc();
        chk("wr_accepted", cmd_vld, 0);
        pulses = 0;
        repeat (200) begin
            cyc();
            if (rsp_vld != 0 || rsp_err != 0) pulses++;
        end
        chk("wr_no_early_rsp", pulses, 0);
        cmd_rdy = 1'b1;
        cyc();
        chk("wr_rsp_vld", rsp_vld, 4'b0001);
        chk("wr_rsp_err", rsp_err, 0);
        cyc();
        chk("wr_single_pulse", rsp_vld, 0);

        // Single read from requester 2
        rc[2] = 16'h0012; req_vld = 4'b0100;
        #1 chk("rd_grant", req_rdy, 4'b0100);
        cyc();
        req_vld = '0;
        chk("rd_cmd_in", cmd_in, 16'h0012);
        cmd_rdy = 1'b0;
        cyc(2);
        read_rdy = 1'b1; read_data = 8'hC3;
        cyc();
        read_rdy = 1'b0; read_data = 8'h00; cmd_rdy = 1'b1;
        chk("rd_rsp_vld", rsp_vld, 4'b0100);
        chk("rd_rsp_data", rsp_data, 8'hC3);
        chk("rd_rsp_err", rsp_err, 0);
        cyc();
        chk("rd_single_pulse", rsp_vld, 0);
        chk("rd_data_hold", rsp_data, 8'hC3);

        // Read failure: engine goes idle without read data
        rc[1] = 16'h0034; req_vld = 4'b0010;
        #1 chk("rdfail_grant", req_rdy, 4'b0010);
        cyc();
        req_vld = '0; cmd_rdy = 1'b0; read_data = 8'h5A;
        cyc();
        cmd_rdy = 1'b1;
        cyc();
        chk("rdfail_rsp_err", rsp_err, 4'b0010);
        chk("rdfail_rsp_vld", rsp_vld, 0);
        chk("rdfail_data_kept", rsp_data, 8'hC3);
        cyc();
        chk("rdfail_single", rsp_err, 0);
        read_data = '0;

        // Read data and engine idle in the same cycle counts as success
        rc[3] = 16'h0056; req_vld = 4'b1000;
        #1 chk("rdboth_grant", req_rdy, 4'b1000);
        cyc();
        req_vld = '0; cmd_rdy = 1'b0;
        cyc();
        cmd_rdy = 1'b1; read_rdy = 1'b1; read_data = 8'h7E;
        cyc();
        read_rdy = 1'b0; read_data = '0;
        chk("rdboth_rsp_vld", rsp_vld, 4'b1000);
        chk("rdboth_rsp_err", rsp_err, 0);
        chk("rdboth_rsp_data", rsp_data, 8'h7E);
        cyc();

        // Request dropped before transfer leaves the pointer alone
        cmd_rdy = 1'b0; req_vld = 4'b0100;
        #1 chk("drop_no_grant", req_rdy, 0);
        cyc();
        req_vld = '0; cmd_rdy = 1'b1;
        cyc();
        req_vld = 4'b1111;
        #1 chk("drop_ptr_kept", req_rdy, 4'b0001);
        cyc();
        req_vld = '0;
        chk("drop_cmd_in", cmd_in, 16'h8A55);
        cmd_rdy = 1'b0;
        cyc();
        cmd_rdy = 1'b1;
        cyc();
        chk("drop_rsp_vld", rsp_vld, 4'b0001);
        cyc();

        // Timeout (TIMEOUT=100 instance): error exactly 100 cycles after accept
        b_req_vld = 4'b0001;
        #1 chk("to_grant", b_req_rdy, 4'b0001);
        cyc();
        b_req_vld = '0;
        chk("to_cmd_vld", b_cmd_vld, 1);
        cmd_rdy = 1'b0;
        cyc();
        chk("to_accepted", b_cmd_vld, 0);
        k_err = -1; err_seen = '0;
        for (int k = 1; k <= 150; k++) begin
            cyc();
            if (b_rsp_err != 0 || b_rsp_vld != 0) begin
                k_err = k;
                err_seen = b_rsp_err;
                break;
            end
        end
        chk("to_latency", k_err, 100);
        chk("to_err_owner", err_seen, 4'b0001);
        cyc();
        chk("to_single", b_rsp_err, 0);
        cmd_rdy = 1'b1; b_req_vld = 4'b0010;
        #1 chk("to_idle_again", b_req_rdy, 4'b0010);
        b_req_vld = '0;
        cyc();

        // Reset while BUSY
        req_vld = 4'b0100;
        #1 chk("rstb_grant", req_rdy, 4'b0100);
        cyc();
        req_vld = '0; cmd_rdy = 1'b0;
        cyc();
        chk("rstb_busy", cmd_vld, 0);
        cyc();
        rst = 1'b1; read_rdy = 1'b1; read_data = 8'h99;
        #1;
        chk("rstb_cmd_vld", cmd_vld, 0);
        chk("rstb_cmd_in", cmd_in, 0);
        chk("rstb_rsp_data", rsp_data, 0);
        chk("rstb_rsp_vld", rsp_vld, 0);
        chk("rstb_rsp_err", rsp_err, 0);
        cyc();
        rst = 1'b0; read_rdy = 1'b0; read_data = '0; cmd_rdy = 1'b1;
        pulses = 0;
        repeat (3) begin
            cyc();
            if (rsp_vld != 0 || rsp_err != 0) pulses++;
        end
        chk("rstb_no_rsp", pulses, 0);
        rc[1] = 16'h8B66; req_vld = 4'b1010;
        #1 chk("rstb_ptr_reset", req_rdy, 4'b0010);
        cyc();
        req_vld = '0;
        chk("rstb_cmd_in_new", cmd_in, 16'h8B66);
        cmd_rdy = 1'b0;
        cyc();
        cmd_rdy = 1'b1;
        cyc();
        chk("rstb_rsp_vld", rsp_vld, 4'b0010);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
